// File: rtl/cpu_pkg.sv
// Shared constants and types for the scalar in-order pipeline.
// ALU control is one-hot; each constant below is a bit index into alu_op.
package cpu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 14;

  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_IMM  = 1;
  localparam int unsigned ALU_OR   = 2;
  localparam int unsigned ALU_SUB  = 3;
  localparam int unsigned ALU_XOR  = 4;
  localparam int unsigned ALU_SRA  = 5;
  localparam int unsigned ALU_AND  = 6;
  localparam int unsigned ALU_SLL  = 7;
  localparam int unsigned ALU_SRL  = 8;
  localparam int unsigned ALU_SLTU = 9;
  localparam int unsigned ALU_NOR  = 10;
  localparam int unsigned ALU_SLT  = 11;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [XLEN-1:0]     src1;
    logic [XLEN-1:0]     src2;
    logic [4:0]          rd;
    logic                rf_we;
    logic                mem_re;
    logic                mem_we;
    logic [XLEN-1:0]     st_data;
  } id_ex_t;

endpackage

// File: rtl/alu.sv
// Combinational one-hot ALU: every selected function is AND-OR merged into y.
// IMM passes src2 through (immediate load); reserved op bits have no effect.
module alu
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 14
) (
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] sra_res;
  logic [XLEN-1:0] slt_res;
  logic [XLEN-1:0] sltu_res;
  logic            unused_rsvd;

  assign unused_rsvd = ^op[OPW-1:12];

  always_comb begin
    shamt    = b[4:0];
    // Computed separately so the arithmetic shift keeps its signed context.
    sra_res  = $signed(a) >>> shamt;
    slt_res  = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
    sltu_res = {{(XLEN-1){1'b0}}, (a < b)};

    y = '0;
    if (op[ALU_ADD])  y = y | (a + b);
    if (op[ALU_IMM])  y = y | b;
    if (op[ALU_OR])   y = y | (a | b);
    if (op[ALU_SUB])  y = y | (a - b);
    if (op[ALU_XOR])  y = y | (a ^ b);
    if (op[ALU_SRA])  y = y | sra_res;
    if (op[ALU_AND])  y = y | (a & b);
    if (op[ALU_SLL])  y = y | (a << shamt);
    if (op[ALU_SRL])  y = y | (a >> shamt);
    if (op[ALU_SLTU]) y = y | sltu_res;
    if (op[ALU_NOR])  y = y | ~(a | b);
    if (op[ALU_SLT])  y = y | slt_res;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: one-entry ID/EX register with valid/ready handshake to MEM,
// ALU on registered operands, and a forwarding port back to decode.
module exe_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [OPW-1:0]  id_alu_op,
  input  logic [XLEN-1:0] id_src1,
  input  logic [XLEN-1:0] id_src2,
  input  logic [4:0]      id_rd,
  input  logic            id_rf_we,
  input  logic            id_mem_re,
  input  logic            id_mem_we,
  input  logic [XLEN-1:0] id_st_data,
  output logic            ex_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_result,
  output logic [XLEN-1:0] ex_st_data,
  output logic [4:0]      ex_rd,
  output logic            ex_rf_we,
  output logic            ex_mem_re,
  output logic            ex_mem_we,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  logic   v_q, v_d;
  id_ex_t pl_q, pl_d;
  id_ex_t in_pl;
  logic   accept;

  always_comb begin
    in_pl         = '0;
    in_pl.pc      = id_pc;
    in_pl.alu_op  = id_alu_op;
    in_pl.src1    = id_src1;
    in_pl.src2    = id_src2;
    in_pl.rd      = id_rd;
    in_pl.rf_we   = id_rf_we;
    in_pl.mem_re  = id_mem_re;
    in_pl.mem_we  = id_mem_we;
    in_pl.st_data = id_st_data;
  end

  always_comb begin
    id_ready = !v_q || mem_ready;
    accept   = id_valid && id_ready && !flush;
    v_d      = v_q;
    pl_d     = pl_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (accept) begin
      v_d  = 1'b1;
      pl_d = in_pl;
    end else if (mem_ready) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= 1'b0;
      pl_q <= '0;
    end else begin
      v_q  <= v_d;
      pl_q <= pl_d;
    end
  end

  alu #(.XLEN(XLEN), .OPW(OPW)) u_alu (
    .op (pl_q.alu_op),
    .a  (pl_q.src1),
    .b  (pl_q.src2),
    .y  (ex_result)
  );

  // Load data is not available in EX, so loads never forward from here.
  always_comb begin
    ex_valid   = v_q;
    ex_pc      = pl_q.pc;
    ex_st_data = pl_q.st_data;
    ex_rd      = pl_q.rd;
    ex_rf_we   = pl_q.rf_we;
    ex_mem_re  = pl_q.mem_re;
    ex_mem_we  = pl_q.mem_we;
    fwd_valid  = v_q && pl_q.rf_we && (pl_q.rd != 5'd0) && !pl_q.mem_re;
    fwd_rd     = pl_q.rd;
    fwd_data   = ex_result;
  end

endmodule
